// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one byte-wide synchronous RAM between the fetch
// port (8-byte reads) and the data port (8-byte reads or writes). Each
// access is eight big-endian byte beats, followed by a tail cycle for the
// last read byte and a one-cycle ack.
//
// Handshake: a requester raises req with addr/wdata stable and holds them
// until it samples its ack high at a rising edge; it drops req at that edge.
// An ack is a single-cycle pulse, err is meaningful only while ack is high,
// and rdata holds its value until that port's next ack.
module mem_port_arbiter #(
    parameter int MEM_BYTES     = 1024,
    parameter int ADDR_W        = 10,
    parameter int DATA_PRIORITY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [63:0]       f_addr,
    output logic [63:0]       f_rdata,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [63:0]       d_addr,
    input  logic [63:0]       d_wdata,
    output logic [63:0]       d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              f_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_TAIL = 2'd2;
    localparam logic [1:0] S_ACK  = 2'd3;

    localparam bit DP = (DATA_PRIORITY != 0);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] base;
    logic              we_q;
    logic [63:0]       wdata_q;
    logic [63:0]       asm_q;
    logic              gnt_data;   // 1 = current access belongs to the data port
    logic              last_data;  // 1 = most recent grant went to the data port

    logic              pick_d;
    logic [63:0]       sel_addr;
    logic              out_of_range;
    logic [63:0]       rd_final;

    // Grant choice: lone requester wins; on a tie, data wins or round-robin.
    always_comb begin
        pick_d = 1'b0;
        if (d_req && f_req) begin
            pick_d = DP ? 1'b1 : !last_data;
        end else begin
            pick_d = d_req;
        end
    end

    assign sel_addr = pick_d ? d_addr : f_addr;
    // 65-bit sum so addresses near 2^64 cannot wrap into range.
    assign out_of_range = ({1'b0, sel_addr} + 65'd7) >= 65'(MEM_BYTES);
    // The eighth read byte arrives during TAIL; writes return zero.
    assign rd_final = we_q ? 64'd0 : {asm_q[55:0], ram_rdata};

    // Access sequencer and registered ack/err/rdata outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            base      <= '0;
            we_q      <= 1'b0;
            wdata_q   <= 64'd0;
            asm_q     <= 64'd0;
            gnt_data  <= 1'b0;
            last_data <= 1'b0;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            f_err     <= 1'b0;
            d_err     <= 1'b0;
            f_rdata   <= 64'd0;
            d_rdata   <= 64'd0;
        end else begin
            f_ack <= 1'b0;
            d_ack <= 1'b0;
            f_err <= 1'b0;
            d_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (f_req || d_req) begin
                        gnt_data  <= pick_d;
                        last_data <= pick_d;
                        base      <= sel_addr[ADDR_W-1:0];
                        we_q      <= pick_d && d_we;
                        wdata_q   <= pick_d ? d_wdata : 64'd0;
                        asm_q     <= 64'd0;
                        cnt       <= 3'd0;
                        if (out_of_range) begin
                            state <= S_ACK;
                            if (pick_d) begin
                                d_ack   <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= 64'd0;
                            end else begin
                                f_ack   <= 1'b1;
                                f_err   <= 1'b1;
                                f_rdata <= 64'd0;
                            end
                        end else begin
                            state <= S_XFER;
                        end
                    end
                end
                S_XFER: begin
                    // ram_rdata carries the byte addressed one beat earlier.
                    if (!we_q && cnt != 3'd0) begin
                        asm_q <= {asm_q[55:0], ram_rdata};
                    end
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    state <= S_ACK;
                    if (gnt_data) begin
                        d_ack   <= 1'b1;
                        d_rdata <= rd_final;
                    end else begin
                        f_ack   <= 1'b1;
                        f_rdata <= rd_final;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // RAM drive: active only during XFER beats, MSB byte first on writes.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 8'd0;
        if (state == S_XFER) begin
            ram_addr = base + ADDR_W'(cnt);
            ram_we   = we_q;
            if (we_q) begin
                ram_wdata = wdata_q[{~cnt, 3'b000} +: 8];
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scoreboard bench. Instance 0 uses data
// priority, instance 1 uses round-robin ties; each has its own RAM model.
// Scoreboard entry: {check_data, port_is_data, err, rdata[63:0]}.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        pl_en;
  logic        f_req     [2];
  logic [63:0] f_addr    [2];
  logic [63:0] f_rdata   [2];
  logic        f_ack     [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [63:0] d_addr    [2];
  logic [63:0] d_wdata   [2];
  logic [63:0] d_rdata   [2];
  logic        d_ack     [2];
  logic        d_err     [2];
  logic        f_err     [2];
  logic [9:0]  ram_addr  [2];
  logic        ram_we    [2];
  logic [7:0]  ram_wdata [2];
  logic [7:0]  ram_rdata [2];
  logic        busy      [2];
  logic [1:0]  dbg_state [2];
  logic [7:0]  mem [2][1024];

  logic [66:0] exp_q0[$];
  logic [66:0] exp_q1[$];
  int n_checks = 0;
  int n_pass = 0;
  int we_total = 0;

  mem_port_arbiter #(.MEM_BYTES(1024), .ADDR_W(10), .DATA_PRIORITY(1)) dut0 (
    .clk(clk), .rst(rst),
    .f_req(f_req[0]), .f_addr(f_addr[0]), .f_rdata(f_rdata[0]), .f_ack(f_ack[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_ack(d_ack[0]), .d_err(d_err[0]), .f_err(f_err[0]),
    .ram_addr(ram_addr[0]), .ram_we(ram_we[0]), .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0]), .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  mem_port_arbiter #(.MEM_BYTES(1024), .ADDR_W(10), .DATA_PRIORITY(0)) dut1 (
    .clk(clk), .rst(rst),
    .f_req(f_req[1]), .f_addr(f_addr[1]), .f_rdata(f_rdata[1]), .f_ack(f_ack[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_ack(d_ack[1]), .d_err(d_err[1]), .f_err(f_err[1]),
    .ram_addr(ram_addr[1]), .ram_we(ram_we[1]), .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1]), .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM models; pl_en loads the initial image in one cycle.
  always @(posedge clk) begin
    if (pl_en) begin
      for (int a = 0; a < 1024; a++) begin
        mem[0][a] <= 8'h00;
        mem[1][a] <= 8'(a + 1);
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ram_we[k]) mem[k][ram_addr[k]] <= ram_wdata[k];
        ram_rdata[k] <= mem[k][ram_addr[k]];
      end
    end
  end

  always @(negedge clk) if (ram_we[0]) we_total++;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got ack expected none", name);
  endtask

  task automatic score(input int k, input logic [66:0] e);
    logic [63:0] got_data;
    logic        got_err;
    got_err  = d_ack[k] ? d_err[k] : f_err[k];
    got_data = d_ack[k] ? d_rdata[k] : f_rdata[k];
    check($sformatf("port%0d", k), 64'(d_ack[k]), 64'(e[65]));
    check($sformatf("err%0d", k), 64'(got_err), 64'(e[64]));
    if (e[66]) check($sformatf("rdata%0d", k), got_data, e[63:0]);
  endtask

  // Monitors: pop one expectation per ack cycle.
  always @(negedge clk) begin
    if (!rst && (f_ack[0] || d_ack[0])) begin
      check("dual_ack0", 64'(f_ack[0] & d_ack[0]), 64'd0);
      if (exp_q0.size() == 0) fail_now("unexp_ack0");
      else score(0, exp_q0.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && (f_ack[1] || d_ack[1])) begin
      check("dual_ack1", 64'(f_ack[1] & d_ack[1]), 64'd0);
      if (exp_q1.size() == 0) fail_now("unexp_ack1");
      else score(1, exp_q1.pop_front());
    end
  end

  // ---------------- driver ----------------
  // Raises req, counts falling edges until ack is seen (0 = timed out),
  // then drops req just after the edge that samples the ack.
  task automatic access(input int k, input bit is_d, input bit we,
                        input logic [63:0] addr, input logic [63:0] wd, output int lat);
    if (is_d) begin
      d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd; d_req[k] = 1'b1;
    end else begin
      f_addr[k] = addr; f_req[k] = 1'b1;
    end
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (is_d ? d_ack[k] : f_ack[k]) begin
        lat = i;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (is_d) d_req[k] = 1'b0;
    else f_req[k] = 1'b0;
  endtask

  function automatic int mem0_sum();
    int s = 0;
    for (int a = 0; a < 1024; a++) s += int'(mem[0][a]);
    return s;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int lat, lat2, w0, s0;
    logic [63:0] v;
    for (int k = 0; k < 2; k++) begin
      f_req[k] = 0; f_addr[k] = 0; d_req[k] = 0; d_we[k] = 0;
      d_addr[k] = 0; d_wdata[k] = 0;
    end
    rst = 1'b1;
    pl_en = 1'b1;
    @(posedge clk); #1 pl_en = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy[0]), 0);
    check("rst_state", 64'(dbg_state[0]), 0);
    check("rst_ram_we", 64'(ram_we[0]), 0);
    check("rst_acks", 64'({f_ack[0], d_ack[0], f_err[0], d_err[0]}), 0);
    check("rst_f_rdata", f_rdata[0], 0);
    check("rst_d_rdata", d_rdata[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // Write 0x0123456789ABCDEF to 16.
    w0 = we_total;
    exp_q0.push_back({1'b0, 1'b1, 1'b0, 64'd0});
    access(0, 1, 1, 64'd16, 64'h0123456789ABCDEF, lat);
    check("wr_latency", 64'(lat), 10);
    check("wr_we_beats", 64'(we_total - w0), 8);
    v = 64'h0123456789ABCDEF;
    for (int i = 0; i < 8; i++) check($sformatf("wr_byte%0d", i), 64'(mem[0][16 + i]), 64'(v[63 - 8*i -: 8]));

    // Fetch it back.
    @(negedge clk);
    exp_q0.push_back({1'b1, 1'b0, 1'b0, 64'h0123456789ABCDEF});
    access(0, 0, 0, 64'd16, 64'd0, lat);
    check("rd_latency", 64'(lat), 10);
    @(negedge clk);
    check("f_ack_pulse", 64'(f_ack[0]), 0);

    // Tie with data priority: data first, fetch 11 cycles later.
    exp_q0.push_back({1'b0, 1'b1, 1'b0, 64'd0});
    exp_q0.push_back({1'b1, 1'b0, 1'b0, 64'h0123456789ABCDEF});
    fork
      access(0, 1, 1, 64'd32, 64'hCAFEBABEDEADBEEF, lat);
      access(0, 0, 0, 64'd16, 64'd0, lat2);
    join
    check("tie_d_latency", 64'(lat), 10);
    check("tie_f_latency", 64'(lat2), 21);
    @(negedge clk);
    exp_q0.push_back({1'b1, 1'b0, 1'b0, 64'hCAFEBABEDEADBEEF});
    access(0, 0, 0, 64'd32, 64'd0, lat);

    // Out of range: 1017 + 7 = 1024, and a near-2^64 address.
    @(negedge clk);
    w0 = we_total;
    s0 = mem0_sum();
    exp_q0.push_back({1'b1, 1'b1, 1'b1, 64'd0});
    access(0, 1, 1, 64'd1017, 64'hFFFFFFFFFFFFFFFF, lat);
    check("err_latency", 64'(lat), 1);
    @(negedge clk);
    exp_q0.push_back({1'b1, 1'b1, 1'b1, 64'd0});
    access(0, 1, 1, 64'hFFFFFFFFFFFFFFFC, 64'h5555555555555555, lat);
    check("wrap_latency", 64'(lat), 1);
    @(negedge clk);
    exp_q0.push_back({1'b1, 1'b0, 1'b1, 64'd0});
    access(0, 0, 0, 64'd1020, 64'd0, lat);
    check("err_we_beats", 64'(we_total - w0), 0);
    check("err_ram_same", 64'(mem0_sum()), 64'(s0));

    // Highest legal base: 1016..1023.
    @(negedge clk);
    exp_q0.push_back({1'b0, 1'b1, 1'b0, 64'd0});
    access(0, 1, 1, 64'd1016, 64'h1122334455667788, lat);
    @(negedge clk);
    exp_q0.push_back({1'b1, 1'b0, 1'b0, 64'h1122334455667788});
    access(0, 0, 0, 64'd1016, 64'd0, lat);
    check("edge_rd_latency", 64'(lat), 10);

    // Round-robin: both ports keep requesting -> data, fetch, data, fetch.
    @(negedge clk);
    exp_q1.push_back({1'b1, 1'b1, 1'b0, 64'h0102030405060708});
    exp_q1.push_back({1'b1, 1'b0, 1'b0, 64'h292A2B2C2D2E2F30});
    exp_q1.push_back({1'b1, 1'b1, 1'b0, 64'h090A0B0C0D0E0F10});
    exp_q1.push_back({1'b1, 1'b0, 1'b0, 64'h3132333435363738});
    fork
      begin
        access(1, 1, 0, 64'd0, 64'd0, lat);
        access(1, 1, 0, 64'd8, 64'd0, lat);
      end
      begin
        access(1, 0, 0, 64'd40, 64'd0, lat2);
        access(1, 0, 0, 64'd48, 64'd0, lat2);
      end
    join

    // Reset after three write beats to 100.
    @(negedge clk);
    d_we[0] = 1; d_addr[0] = 64'd100; d_wdata[0] = 64'hA1A2A3A4A5A6A7A8; d_req[0] = 1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    d_req[0] = 0;
    #1;
    check("mid_rst_state", 64'(dbg_state[0]), 0);
    check("mid_rst_busy", 64'(busy[0]), 0);
    check("mid_rst_ram_we", 64'(ram_we[0]), 0);
    check("mid_rst_f_rdata", f_rdata[0], 0);
    check("mid_rst_acks", 64'({f_ack[0], d_ack[0]}), 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_b0", 64'(mem[0][100]), 64'hA1);
    check("mid_rst_b1", 64'(mem[0][101]), 64'hA2);
    check("mid_rst_b2", 64'(mem[0][102]), 64'hA3);
    check("mid_rst_b3", 64'(mem[0][103]), 64'h00);
    @(negedge clk);
    exp_q0.push_back({1'b1, 1'b0, 1'b0, 64'hA1A2A3_0000000000});
    access(0, 0, 0, 64'd100, 64'd0, lat);
    check("post_rst_latency", 64'(lat), 10);

    repeat (3) @(negedge clk);
    check("q0_drained", 64'(exp_q0.size()), 0);
    check("q1_drained", 64'(exp_q1.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
